// File: rtl/uart_tx_sched.sv
// Round-robin scheduler that feeds bytes from NUM_REQ requesters into one uart_trans input bus.
// Define UART_TX_SCHED_PRIO_EN to make requester 0 win every arbitration it takes part in.
module uart_tx_sched #(
  parameter int DATA_SIZE  = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 16,
  parameter int GAP_CYCLES = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  input  logic [NUM_REQ*DATA_SIZE-1:0]   req_data_i,
  input  logic [NUM_REQ-1:0]             req_last_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  output logic                           trans_o,
  output logic [DATA_SIZE-1:0]           bus_data_in_o,
  input  logic                           wait_request_i,
  output logic [$clog2(NUM_REQ)-1:0]     grant_id_o,
  output logic                           grant_active_o,
  output logic                           timeout_err_o
);

  localparam int ID_W     = $clog2(NUM_REQ);
  localparam int BW       = $clog2(MAX_BURST + 1);
  localparam int SW       = $clog2(TIMEOUT + 1);
  localparam int GW       = $clog2(GAP_CYCLES + 2);
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  typedef enum logic [2:0] {S_IDLE, S_ARB, S_LOAD, S_ISSUE, S_GAP} state_t;

  state_t               state_q, state_d;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]      grant_q, grant_d;
  logic [BW-1:0]        burst_q, burst_d;
  logic [SW-1:0]        stall_q, stall_d;
  logic [GW-1:0]        gap_q, gap_d;
  logic [DATA_SIZE-1:0] hold_q, hold_d;
  logic                 last_q, last_d;
  logic                 trans_q, trans_d;
  logic [DATA_SIZE-1:0] bus_q, bus_d;
  logic [NUM_REQ-1:0]   ready_q, ready_d;
  logic                 active_q, active_d;
  logic                 tout_q, tout_d;

  logic [DATA_SIZE-1:0] req_byte [NUM_REQ];
  logic                 arb_found;
  logic [ID_W-1:0]      arb_idx;
  logic [ID_W-1:0]      arb_cand;
  logic [ID_W-1:0]      rr_next;
  logic [ID_W-1:0]      rr_upd;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign req_byte[gi] = req_data_i[gi*DATA_SIZE +: DATA_SIZE];
      assign ready_d[gi]  = (state_d == S_LOAD) && (grant_d == ID_W'(gi));
    end
  endgenerate

  assign rr_next = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + ID_W'(1);
`ifdef UART_TX_SCHED_PRIO_EN
  // A frame owned by the priority requester leaves the rotation where it was.
  assign rr_upd = (grant_q == '0) ? rr_ptr_q : rr_next;
`else
  assign rr_upd = rr_next;
`endif

  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    arb_cand  = '0;
`ifdef UART_TX_SCHED_PRIO_EN
    if (req_valid_i[0]) arb_found = 1'b1;
`endif
    for (int k = 0; k < NUM_REQ; k++) begin
      arb_cand = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!arb_found && req_valid_i[arb_cand]) begin
        arb_found = 1'b1;
        arb_idx   = arb_cand;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    burst_d  = burst_q;
    stall_d  = stall_q;
    gap_d    = gap_q;
    hold_d   = hold_q;
    last_d   = last_q;
    tout_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (|req_valid_i) state_d = S_ARB;
      end
      S_ARB: begin
        if (arb_found) begin
          grant_d = arb_idx;
          burst_d = '0;
          stall_d = '0;
          state_d = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (req_valid_i[grant_q]) begin
          hold_d  = req_byte[grant_q];
          last_d  = req_last_i[grant_q];
          state_d = S_ISSUE;
        end else begin
          stall_d = stall_q + SW'(1);
          if (stall_q + SW'(1) == SW'(TIMEOUT)) begin
            tout_d  = 1'b1;
            gap_d   = '0;
            state_d = S_GAP;
          end
        end
      end
      S_ISSUE: begin
        // Byte stays on the bus for as long as the transmitter pushes back.
        if (!wait_request_i) begin
          burst_d = burst_q + BW'(1);
          if (last_q || burst_q == BW'(MAX_BURST - 1)) begin
            gap_d   = '0;
            state_d = S_GAP;
          end else begin
            stall_d = '0;
            state_d = S_LOAD;
          end
        end
      end
      S_GAP: begin
        if (gap_q == GW'(GAP_LAST)) begin
          rr_ptr_d = rr_upd;
          state_d  = S_IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign trans_d  = (state_d == S_ISSUE);
  assign bus_d    = trans_d ? hold_d : '0;
  assign active_d = (state_d == S_LOAD) || (state_d == S_ISSUE);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      burst_q  <= '0;
      stall_q  <= '0;
      gap_q    <= '0;
      hold_q   <= '0;
      last_q   <= 1'b0;
      trans_q  <= 1'b0;
      bus_q    <= '0;
      ready_q  <= '0;
      active_q <= 1'b0;
      tout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      burst_q  <= burst_d;
      stall_q  <= stall_d;
      gap_q    <= gap_d;
      hold_q   <= hold_d;
      last_q   <= last_d;
      trans_q  <= trans_d;
      bus_q    <= bus_d;
      ready_q  <= ready_d;
      active_q <= active_d;
      tout_q   <= tout_d;
    end
  end

  assign req_ready_o    = ready_q;
  assign trans_o        = trans_q;
  assign bus_data_in_o  = bus_q;
  assign grant_id_o     = grant_q;
  assign grant_active_o = active_q;
  assign timeout_err_o  = tout_q;

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
Scheduler that shares one uart_trans transmitter between NUM_REQ byte requesters. It runs round-robin arbitration and locks the grant for one frame, which is a burst ending on req_last or at MAX_BURST bytes. It holds each byte on trans/bus_data_in until the transmitter accepts it. It sits between the host-side byte sources and the uart_trans input bus.

Parameters:
DATA_SIZE, 8, byte width; matches uart_trans DATA_SIZE
NUM_REQ, 4, number of requesters (2..8)
MAX_BURST, 16, maximum bytes per grant; matches the uart_trans SIZE_FIFO depth
GAP_CYCLES, 4, idle clk cycles inserted after each frame before re-arbitration
TIMEOUT, 255, cycles a granted requester may stall (req_valid low) before the grant is revoked

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-requester byte valid
req_data  in  NUM_REQ*DATA_SIZE  packed bytes; requester i uses bits [i*DATA_SIZE +: DATA_SIZE]
req_last  in  NUM_REQ  byte is the last of the requester's frame
req_ready  out  NUM_REQ  one-hot byte accept; requester byte transfers when valid&ready
trans  out  1  byte strobe to uart_trans
bus_data_in  out  DATA_SIZE  byte to uart_trans
wait_request  in  1  from uart_trans; high = byte not accepted this cycle
grant_id  out  clog2(NUM_REQ)  current owner
grant_active  out  1  a grant is held (states LOAD/ISSUE)
timeout_err  out  1  one-cycle pulse when a grant is revoked by timeout

Behaviour:
- Reset (async, active-high): state IDLE, rr_ptr=0, grant_id=0. All of the following are 0: grant_active, trans, bus_data_in, req_ready, timeout_err, burst_cnt, gap_cnt, stall_cnt.
- All outputs are registered. req_ready is decoded from registered state and grant_id.
- IDLE: if any req_valid is high -> ARB; else stay.
- ARB (1 cycle):
  - grant_id = first i with req_valid[i], searching from rr_ptr upward with wrap at NUM_REQ.
  - If no valid remains -> IDLE.
  - Otherwise burst_cnt=0, stall_cnt=0 -> LOAD.
- Latency: req_valid rising in IDLE -> req_ready at earliest on cycle 3 (IDLE, ARB, LOAD).
- LOAD:
  - req_ready[grant_id]=1.
  - On req_valid[grant_id]: capture byte and last flag into the holding register -> ISSUE.
  - Else stall_cnt++. At stall_cnt==TIMEOUT: pulse timeout_err -> GAP.
- ISSUE:
  - trans=1, bus_data_in=holding byte, req_ready all 0.
  - A byte is accepted on the edge where trans=1 and wait_request=0. Then burst_cnt++.
  - After acceptance: if last flag set, or burst_cnt==MAX_BURST-1 before increment -> GAP; else stall_cnt=0 -> LOAD.
  - While wait_request=1: hold trans and bus_data_in stable indefinitely (no timeout in ISSUE).
  - trans drops to 0 and bus_data_in returns to 0 the cycle after acceptance.
- GAP:
  - trans=0, grant_active=0.
  - gap_cnt counts GAP_CYCLES cycles, then -> IDLE with rr_ptr=(grant_id+1) mod NUM_REQ.
  - GAP_CYCLES=0 means a single GAP cycle.
- Boundary conditions:
  - Exactly one byte per LOAD/ISSUE pair; no byte is lost or duplicated across wait_request stalls.
  - A requester dropping req_valid mid-frame does not release the grant until TIMEOUT.
  - req_last on the first byte gives a 1-byte frame.
  - A MAX_BURST cut does not consume or require req_last. The requester re-arbitrates for the rest of its frame.
  - Requests from non-granted requesters are ignored until ARB.
  - All requesters valid: grants rotate 0,1,2,3,0...
  - Reset mid-ISSUE aborts the byte: trans=0 immediately.

Optional Feature:
UART_TX_SCHED_PRIO_EN
- Defined: requester 0 is high priority. In ARB, if req_valid[0]=1 it wins regardless of rr_ptr, and rr_ptr is not advanced after its frame. It never preempts a grant already held.
- Undefined: pure round-robin as above.

Test Plan:
- Single requester 2 sends 3 bytes 0x1E,0xE1,0xAB (last on 0xAB), wait_request=0 -> trans pulses carry 0x1E,0xE1,0xAB in order; grant_id=2; then GAP 4 cycles, IDLE, rr_ptr=3.
- All 4 requesters valid, 1-byte frames 0x10,0x11,0x12,0x13 -> bus_data_in order 0x10,0x11,0x12,0x13,0x10 (requester 0 re-grant); with UART_TX_SCHED_PRIO_EN and req 0 always valid -> only 0x10 repeats.
- wait_request held high 100 cycles during ISSUE with byte 0xFA -> trans=1, bus_data_in=0xFA stable all 100 cycles; exactly one acceptance; req_ready stays 0.
- Requester 1 streams 20 bytes 0x00..0x13, last only on 0x13 -> first grant ends after 0x0F (16 bytes); GAP; re-grant delivers 0x10..0x13.
- Granted requester 3 drops req_valid after 1 byte -> after 255 stall cycles timeout_err pulses once; grant released; rr_ptr=0.
- Assert reset during ISSUE of 0xFF -> trans and all outputs 0 asynchronously; after release, state IDLE and next frame starts from requester 0.
